// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU, with a one-entry response register.
// Latency: a grant in cycle N shows rsp_valid/rsp_data in cycle N+1; one op per cycle while rsp_ready is held high.
// Backpressure: while the response is full and rsp_ready=0, both requesters see ready=0 and the response holds steady.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0] state;
    logic       last_grant;
    logic       can_accept;
    logic       grant_any;
    logic       grant_sel;

    // A full register may drain and refill in the same cycle, which is what keeps throughput at one op per cycle.
    assign can_accept = (state == ST_EMPTY) || rsp_ready;
    assign grant_any  = !reset && can_accept && (req0_valid || req1_valid);

    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    assign req0_ready = grant_any && !grant_sel;
    assign req1_ready = grant_any &&  grant_sel;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 4'b0000;
        if (grant_any) begin
            if (grant_sel) begin
                alu_a    = req1_a;
                alu_b    = req1_b;
                alu_ctrl = req1_ctrl;
            end else begin
                alu_a    = req0_a;
                alu_b    = req0_b;
                alu_ctrl = req0_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
        end else if (grant_any) begin
            state      <= ST_FULL;
            last_grant <= grant_sel;
            rsp_id     <= grant_sel;
            rsp_data   <= alu_out;
            rsp_zero   <= alu_zero;
            rsp_carry  <= alu_carry;
        end else if (state == ST_FULL && rsp_ready) begin
            // Drained with nothing to refill: payload fields keep their last value.
            state <= ST_EMPTY;
        end
    end

    assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: emulates the shared ALU and checks grants, ALU bus and responses against a cycle model.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_ctrl;
    logic         alu_zero, alu_carry;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry;
    logic [W-1:0] rsp_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic         m_full, m_id, m_zero, m_carry, m_last;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
    );

    // Shared ALU: returns {carry, result}; carry is carry-out for ADD and borrow for SUB.
    function automatic logic [W:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'b0000: return {1'b0, a} + {1'b0, b};
            4'b1000: return {(a < b), a - b};
            4'b0111: return {1'b0, a & b};
            4'b0110: return {1'b0, a | b};
            4'b0100: return {1'b0, a ^ b};
            4'b0010: return {1'b0, W'($signed(a) < $signed(b))};
            4'b0011: return {1'b0, W'(a < b)};
            4'b0001: return {1'b0, a << b[4:0]};
            4'b0101: return {1'b0, a >> b[4:0]};
            4'b1101: return {1'b0, W'($signed(a) >>> b[4:0])};
            default: return '0;
        endcase
    endfunction

    logic [W:0] alu_res;
    always_comb begin
        alu_res   = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_out   = alu_res[W-1:0];
        alu_carry = alu_res[W];
        alu_zero  = (alu_res[W-1:0] == '0);
    end

    // Who the rules say should be served this cycle: -1 for nobody.
    function automatic int exp_grant();
        if (reset) return -1;
        if (m_full && !rsp_ready) return -1;
        if (req0_valid && req1_valid) return (m_last == 1'b0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Clock one edge and move the model forward using the inputs presented before the edge.
    task automatic advance();
        int g;
        logic [W:0] r;
        logic rst;
        g   = exp_grant();
        rst = reset;
        r   = (g == 1) ? alu_fn(req1_ctrl, req1_a, req1_b) : alu_fn(req0_ctrl, req0_a, req0_b);
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_id = 0; m_data = '0; m_zero = 0; m_carry = 0; m_last = 1;
        end else if (g >= 0) begin
            m_full = 1; m_id = g[0]; m_data = r[W-1:0]; m_carry = r[W]; m_zero = (r[W-1:0] == '0); m_last = g[0];
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; rsp_ready = 0;
        advance();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'h11; req0_b = 32'h22; req0_ctrl = 4'b0000;
        req1_a = 32'h33; req1_b = 32'h44; req1_ctrl = 4'b0110;
        advance();
        #2;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b need 00", req0_ready, req1_ready); end
        checks++; if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== 4'b0) begin errors++; $display("FAIL reset_alu_idle: got a=%h b=%h c=%b need zeros", alu_a, alu_b, alu_ctrl); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0 || rsp_carry !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got v=%b d=%h id=%b z=%b c=%b need all 0", rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_carry); end
        reset = 0; idle_inputs();
    endtask

    task automatic test_single_add();
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = 4'b0000;
        #2;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL add_ready: got %b%b need 10", req0_ready, req1_ready); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== 4'b0000) begin errors++; $display("FAIL add_alu_bus: got a=%h b=%h c=%b need 5 7 0000", alu_a, alu_b, alu_ctrl); end
        advance();
        idle_inputs();
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL add_rsp: got v=%b id=%b d=%h z=%b need 1 0 0000000c 0", rsp_valid, rsp_id, rsp_data, rsp_zero); end
        advance();
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd12) begin errors++; $display("FAIL add_drain: got v=%b d=%h need 0 0000000c", rsp_valid, rsp_data); end
    endtask

    task automatic test_both_valid();
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 3; req0_b = 5; req0_ctrl = 4'b1000;
        req1_valid = 1; req1_a = 9; req1_b = 9; req1_ctrl = 4'b0100;
        #2;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_first_grant: got %b%b need 10", req0_ready, req1_ready); end
        advance();
        #2;
        checks++; if (rsp_id !== 1'b0 || rsp_data !== 32'hFFFF_FFFE || rsp_carry !== 1'b1) begin
            errors++; $display("FAIL both_rsp0: got id=%b d=%h c=%b need 0 fffffffe 1", rsp_id, rsp_data, rsp_carry); end
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL both_second_grant: got %b%b need 01", req0_ready, req1_ready); end
        advance();
        idle_inputs();
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h0 || rsp_zero !== 1'b1) begin
            errors++; $display("FAIL both_rsp1: got v=%b id=%b d=%h z=%b need 1 1 00000000 1", rsp_valid, rsp_id, rsp_data, rsp_zero); end
        advance();
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'b0000;
            req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'b0111;
            advance();
            #2;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== i[0] || rsp_data !== m_data) begin
                errors++; $display("FAIL b2b_%0d: got v=%b id=%b d=%h need 1 %b %h", i, rsp_valid, rsp_id, rsp_data, i[0], m_data); end
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 32'h100; req0_b = 32'h23; req0_ctrl = 4'b0000;
        advance();
        held = 32'h123;
        rsp_ready = 0;
        req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 4'b0110;
        req0_a = 32'h1; req0_b = 32'h1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b%b need 00", i, req0_ready, req1_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== held || rsp_zero !== 1'b0 || rsp_carry !== 1'b0) begin
                errors++; $display("FAIL stall_hold_%0d: got v=%b id=%b d=%h need 1 0 %h", i, rsp_valid, rsp_id, rsp_data, held); end
            advance();
        end
        rsp_ready = 1;
        #2;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL stall_refill_grant: got %b%b need 01", req0_ready, req1_ready); end
        advance();
        idle_inputs();
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'hFF) begin
            errors++; $display("FAIL stall_refill_rsp: got v=%b id=%b d=%h need 1 1 000000ff", rsp_valid, rsp_id, rsp_data); end
        advance();
    endtask

    task automatic test_ops();
        logic [3:0]   codes [4] = '{4'b0010, 4'b0011, 4'b1101, 4'b1111};
        logic [W-1:0] as    [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        logic [W-1:0] bs    [4] = '{32'd1, 32'd1, 32'd4, 32'd3};
        logic [W-1:0] want  [4] = '{32'd1, 32'd0, 32'hF800_0000, 32'd0};
        do_reset();
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1; req1_a = as[i]; req1_b = bs[i]; req1_ctrl = codes[i];
            #2;
            checks++; if (alu_ctrl !== codes[i]) begin errors++; $display("FAIL op_ctrl_pass_%0d: got %b need %b", i, alu_ctrl, codes[i]); end
            advance();
            idle_inputs();
            #2;
            checks++; if (rsp_id !== 1'b1 || rsp_data !== want[i]) begin errors++; $display("FAIL op_result_%0d: got id=%b d=%h need 1 %h", i, rsp_id, rsp_data, want[i]); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 32'd40; req0_b = 32'd2; req0_ctrl = 4'b0000;
        advance();
        rsp_ready = 0;
        req1_valid = 1;
        advance();
        reset = 1;
        #2;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b%b need 00", req0_ready, req1_ready); end
        advance();
        reset = 0;
        #2;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin errors++; $display("FAIL mid_reset_discard: got v=%b d=%h need 0 00000000", rsp_valid, rsp_data); end
        rsp_ready = 1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_favour: got %b%b need 10", req0_ready, req1_ready); end
        advance();
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        logic [3:0] codes [11] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0010, 4'b0100, 4'b0001, 4'b0011, 4'b0101, 4'b1101, 4'b1010};
        int g;
        logic [W-1:0] ea, eb;
        logic [3:0]   ec;
        int wait0, wait1;
        wait0 = 0; wait1 = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = $urandom; req0_b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
            req1_a = $urandom; req1_b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
            req0_ctrl = codes[$urandom_range(0, 10)];
            req1_ctrl = codes[$urandom_range(0, 10)];
            #2;
            g  = exp_grant();
            ea = (g == 1) ? req1_a : (g == 0) ? req0_a : '0;
            eb = (g == 1) ? req1_b : (g == 0) ? req0_b : '0;
            ec = (g == 1) ? req1_ctrl : (g == 0) ? req0_ctrl : 4'b0;
            checks++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                errors++; $display("FAIL rnd_ready_%0d: got %b%b need grant %0d", i, req0_ready, req1_ready, g); end
            checks++; if (alu_a !== ea || alu_b !== eb || alu_ctrl !== ec) begin
                errors++; $display("FAIL rnd_alu_%0d: got %h %h %b need %h %h %b", i, alu_a, alu_b, alu_ctrl, ea, eb, ec); end
            checks++; if (rsp_valid !== m_full || rsp_id !== m_id || rsp_data !== m_data || rsp_zero !== m_zero || rsp_carry !== m_carry) begin
                errors++; $display("FAIL rnd_rsp_%0d: got v=%b id=%b d=%h z=%b c=%b need %b %b %h %b %b",
                                   i, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry, m_full, m_id, m_data, m_zero, m_carry); end
            // Fairness: a requester left waiting through grant cycles must not be skipped twice in a row.
            if (g >= 0) begin
                wait0 = (req0_valid && g != 0) ? wait0 + 1 : 0;
                wait1 = (req1_valid && g != 1) ? wait1 + 1 : 0;
                checks++; if (wait0 > 1 || wait1 > 1) begin errors++; $display("FAIL rnd_fair_%0d: got waits %0d/%0d need <=1", i, wait0, wait1); end
            end
            if (reset) begin wait0 = 0; wait1 = 0; end
            advance();
        end
        reset = 0;
        idle_inputs();
        advance();
    endtask

    initial begin
        m_full = 0; m_id = 0; m_data = '0; m_zero = 0; m_carry = 0; m_last = 1;
        reset = 1; rsp_ready = 0;
        idle_inputs();
        test_reset();
        test_single_add();
        test_both_valid();
        test_back_to_back();
        test_stall();
        test_ops();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester N's operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands.
REQ-007 req0_ctrl / req1_ctrl  input  4 each  ALU op code, codebase encoding: ADD 0000, SUB 1000, AND 0111, OR 0110, SLT 0010, XOR 0100, SLL 0001, SLTU 0011, SRL 0101, SRA 1101.
REQ-008 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-009 alu_ctrl  output  4  op code driven to the shared ALU.
REQ-010 alu_out  input  WIDTH; alu_zero  input  1; alu_carry  input  1  combinational results from the shared ALU.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-013 rsp_id  output  1  requester that issued the held result (0 or 1).
REQ-014 rsp_data  output  WIDTH; rsp_zero  output  1; rsp_carry  output  1  registered alu_out/alu_zero/alu_carry.

Function
REQ-015 One-entry response register, two states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-016 can_accept = EMPTY, or FULL with rsp_ready=1 (drain and refill same cycle).
REQ-017 Grant only when can_accept=1 and at least one reqN_valid=1; at most one grant per cycle.
REQ-018 Exactly one requester valid: it is granted.
REQ-019 Both valid: round-robin; grant the requester not granted last; last_grant pointer updates only on a grant.
REQ-020 reqN_ready=1 only in the cycle requester N is granted; otherwise 0; combinational from valids, state, rsp_ready, pointer.
REQ-021 Granted cycle: alu_a/alu_b/alu_ctrl driven combinationally from the granted requester; no grant: alu_a=0, alu_b=0, alu_ctrl=0000.
REQ-022 On grant, next edge loads rsp_data=alu_out, rsp_zero=alu_zero, rsp_carry=alu_carry, rsp_id=granted index, state FULL; latency accept->rsp_valid exactly 1 cycle.
REQ-023 FULL, rsp_ready=0: response fields held bit-stable, both reqN_ready=0.
REQ-024 FULL, rsp_ready=1, no grant: next state EMPTY; rsp_data/rsp_id/flags keep last value.
REQ-025 Throughput: one operation per cycle sustained while rsp_ready=1.
REQ-026 Fairness: a requester holding valid is granted within 2 grant cycles.
REQ-027 Op codes outside REQ-007 passed through unchanged; result is whatever ALU returns (0 for default).
REQ-028 No arithmetic performed in this block; result bits copied verbatim, no width change.

Reset
REQ-029 reset=1 at an edge: state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_zero=0, rsp_carry=0, last_grant=1 (req0 favoured next).
REQ-030 While reset=1: req0_ready=0, req1_ready=0, ALU outputs at idle values; any held response discarded, no grant taken.
REQ-031 Reset mid-operation (FULL, rsp_ready=0) discards the pending result without handshake.

Verification
REQ-032 After reset, req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
REQ-033 After reset, both valid same cycle: req0 SUB 3-5, req1 XOR 9^9 -> cycle1 rsp_id=0 data=0xFFFFFFFE carry=1; cycle2 rsp_id=1 data=0 zero=1.
REQ-034 Both valid continuously 6 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1, one result per cycle, no bubbles.
REQ-035 rsp FULL, rsp_ready=0 for 4 cycles with both valid -> both ready=0, rsp fields unchanged; rsp_ready=1 -> same-cycle refill, next result from round-robin winner.
REQ-036 req1 SLT a=0xFFFFFFFF b=1 -> rsp_data=1; SLTU same operands -> rsp_data=0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-037 reset=1 while FULL and rsp_ready=0 -> next cycle rsp_valid=0, rsp_data=0; first post-reset simultaneous request grants req0.
